// File: rtl/hilo_muldiv.sv
// HI/LO register file with single-cycle MULT/MULTU, MT/MF moves and a 32-iteration restoring divider.
// Optional: define DIV_ZERO_FAST_EN to finish a divide by zero after one stall cycle without writing HI/LO.
module hilo_muldiv #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [7:0]  alucontrol_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [31:0] hi, lo;
  logic [5:0]  cnt;
  logic [31:0] dvd, dvs, rem;
  logic        neg_q, neg_r, skip_wr;

  logic        is_div, is_sdiv, zero_skip;
  logic [31:0] a_abs, b_abs;
  logic [63:0] prod_s, prod_u;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, dvd_nx;

  assign is_sdiv = (alucontrol_i == EXE_DIV_OP);
  assign is_div  = is_sdiv | (alucontrol_i == EXE_DIVU_OP);
  assign a_abs   = (is_sdiv && a_i[31]) ? -a_i : a_i;
  assign b_abs   = (is_sdiv && b_i[31]) ? -b_i : b_i;

`ifdef DIV_ZERO_FAST_EN
  assign zero_skip = (b_i == 32'd0);
`else
  assign zero_skip = 1'b0;
`endif

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Restoring step: the quotient register doubles as the dividend shifter.
  assign rem_sh = {rem, dvd[31]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign rem_nx = diff[32] ? rem_sh[31:0] : diff[31:0];
  assign dvd_nx = {dvd[30:0], ~diff[32]};

  always_comb begin
    state_nx = state;
    stall_o  = 1'b0;
    if (flush_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (valid_i && is_div) begin
          stall_o  = 1'b1;
          state_nx = zero_skip ? DONE : BUSY;
        end
        BUSY: begin
          stall_o = 1'b1;
          if (cnt == 6'(DIV_ITERS - 1)) state_nx = DONE;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      skip_wr <= 1'b0;
    end else begin
      state <= state_nx;
      if (!flush_i) begin
        case (state)
          IDLE: if (valid_i) begin
            case (alucontrol_i)
              EXE_MTHI_OP:  hi <= a_i;
              EXE_MTLO_OP:  lo <= a_i;
              EXE_MULT_OP:  {hi, lo} <= prod_s;
              EXE_MULTU_OP: {hi, lo} <= prod_u;
              EXE_DIV_OP, EXE_DIVU_OP: begin
                dvd     <= a_abs;
                dvs     <= b_abs;
                rem     <= '0;
                cnt     <= '0;
                neg_q   <= is_sdiv & (a_i[31] ^ b_i[31]);
                neg_r   <= is_sdiv & a_i[31];
                skip_wr <= zero_skip;
              end
              default: ;
            endcase
          end
          BUSY: begin
            rem <= rem_nx;
            dvd <= dvd_nx;
            cnt <= cnt + 6'd1;
          end
          // DIV is still held in EX here; returning to IDLE on this edge keeps it from restarting.
          DONE: if (!skip_wr) begin
            lo <= neg_q ? -dvd : dvd;
            hi <= neg_r ? -rem : rem;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    result_o = 32'd0;
    if (alucontrol_i == EXE_MFHI_OP)      result_o = hi;
    else if (alucontrol_i == EXE_MFLO_OP) result_o = lo;
  end

  assign hi_o = hi;
  assign lo_o = lo;
endmodule
